gpio_pad_cfg_seq: RTL and testbench

//  Per-pad GPIO configuration bank and staged-apply sequencer between the SoC core and openframe pad controls.

---
 rtl/gpio_pad_cfg_seq.sv | 154 +++++++++++++++
 tb/tb_gpio_pad_cfg_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_cfg_seq.sv
// gpio_pad_cfg_seq
//   Per-pad GPIO configuration bank with a staged-apply sequencer, sitting
//   between the SoC core and the openframe pad-control wrapper.
//
//   The core reads and writes per-pad shadow words over a valid/ready port.
//   An apply pulse copies the shadow bank into the live pad-control outputs,
//   one pad per clock, so that pads never all switch on the same edge.
//
// Ports
//   clk, resetb        core clock, synchronous active-low reset
//   cfg_valid/ready    request handshake (accepted when both are high)
//   cfg_we             1 = write shadow[cfg_addr], 0 = read it
//   cfg_addr           pad index (out-of-range writes ignored, reads give 0)
//   cfg_wdata          12-bit pad configuration word
//   cfg_rdata/rvalid   read data and its one-cycle strobe
//   apply_start        pulse that begins a staged apply (IDLE only)
//   apply_busy         high while the sequencer is in APPLY or DONE
//   apply_done         one-cycle pulse at the end of an apply
//   gpio_*             live per-pad control vectors, one bit per pad
//
// Word layout: [2:0] dm, [3] oeb, [4] inp_dis, [5] ib_mode_sel,
//   [6] vtrip_sel, [7] slow_sel, [8] holdover, [9] analog_en,
//   [10] analog_sel, [11] analog_pol.

module gpio_pad_cfg_seq #(
  parameter int NPADS = 44,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [11:0]      cfg_wdata,
  output logic [11:0]      cfg_rdata,
  output logic             cfg_rvalid,
  input  logic             apply_start,
  output logic             apply_busy,
  output logic             apply_done,
  output logic [NPADS-1:0] gpio_dm2,
  output logic [NPADS-1:0] gpio_dm1,
  output logic [NPADS-1:0] gpio_dm0,
  output logic [NPADS-1:0] gpio_oeb,
  output logic [NPADS-1:0] gpio_inp_dis,
  output logic [NPADS-1:0] gpio_ib_mode_sel,
  output logic [NPADS-1:0] gpio_vtrip_sel,
  output logic [NPADS-1:0] gpio_slow_sel,
  output logic [NPADS-1:0] gpio_holdover,
  output logic [NPADS-1:0] gpio_analog_en,
  output logic [NPADS-1:0] gpio_analog_sel,
  output logic [NPADS-1:0] gpio_analog_pol
);

  // Safe pad default: digital input (dm=001), output buffer disabled.
  localparam logic [11:0]      DEF      = 12'h009;
  localparam logic [IDX_W:0]   NPADS_X  = (IDX_W+1)'(NPADS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPADS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [11:0]      shadow [NPADS];
  logic [11:0]      live   [NPADS];
  logic             accept;
  logic             addr_ok;

  assign accept  = cfg_valid & cfg_ready;
  // One extra bit so the compare still works when NPADS == 2**IDX_W.
  assign addr_ok = ({1'b0, cfg_addr} < NPADS_X);

  // Next-state logic. apply_start is only looked at in IDLE, so a pulse
  // arriving during an apply is simply dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (apply_start) state_nxt = APPLY;
      APPLY:   if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pad index and the registered ready flag. Ready is derived from
  // the next state, so it drops on the same edge the apply begins and rises
  // on the edge that returns to IDLE.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= IDLE;
      idx       <= '0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == IDLE);
      if (state == APPLY) idx <= idx + 1'b1;
      else                idx <= '0;
    end
  end

  // Shadow bank. Requests cannot be accepted outside IDLE, which keeps the
  // bank frozen while it is being copied.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int k = 0; k < NPADS; k++) shadow[k] <= DEF;
    end else if (accept && cfg_we && addr_ok) begin
      shadow[cfg_addr] <= cfg_wdata;
    end
  end

  // Live bank: exactly one pad is copied per APPLY cycle. Reset restores
  // every pad, so an interrupted apply leaves nothing half-applied.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int k = 0; k < NPADS; k++) live[k] <= DEF;
    end else if (state == APPLY) begin
      live[idx] <= shadow[idx];
    end
  end

  // Read path: data appears one cycle after acceptance and is zero at any
  // other time, including reads of nonexistent pads.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= accept && !cfg_we;
      if (accept && !cfg_we && addr_ok) cfg_rdata <= shadow[cfg_addr];
      else                              cfg_rdata <= '0;
    end
  end

  assign apply_busy = (state != IDLE);
  assign apply_done = (state == DONE);

  // Fan the live words out into the per-field pad vectors.
  for (genvar k = 0; k < NPADS; k++) begin : g_pad
    assign gpio_dm0[k]         = live[k][0];
    assign gpio_dm1[k]         = live[k][1];
    assign gpio_dm2[k]         = live[k][2];
    assign gpio_oeb[k]         = live[k][3];
    assign gpio_inp_dis[k]     = live[k][4];
    assign gpio_ib_mode_sel[k] = live[k][5];
    assign gpio_vtrip_sel[k]   = live[k][6];
    assign gpio_slow_sel[k]    = live[k][7];
    assign gpio_holdover[k]    = live[k][8];
    assign gpio_analog_en[k]   = live[k][9];
    assign gpio_analog_sel[k]  = live[k][10];
    assign gpio_analog_pol[k]  = live[k][11];
  end

endmodule

// File: tb/tb_gpio_pad_cfg_seq.sv
// tb_gpio_pad_cfg_seq
//   Directed bench for gpio_pad_cfg_seq. Inputs are driven and outputs are
//   sampled on the falling clock edge, half a period away from the rising
//   edge the design acts on.

module tb_gpio_pad_cfg_seq;

  localparam int          NPADS = 44;
  localparam int          IDX_W = 6;
  localparam logic [11:0] DEF   = 12'h009;
  localparam logic [NPADS-1:0] ONES  = '1;
  localparam logic [NPADS-1:0] ZEROS = '0;

  logic             clk;
  logic             resetb;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [11:0]      cfg_wdata;
  logic [11:0]      cfg_rdata;
  logic             cfg_rvalid;
  logic             apply_start;
  logic             apply_busy;
  logic             apply_done;
  logic [NPADS-1:0] gpio_dm2, gpio_dm1, gpio_dm0, gpio_oeb, gpio_inp_dis;
  logic [NPADS-1:0] gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel;
  logic [NPADS-1:0] gpio_holdover, gpio_analog_en, gpio_analog_sel, gpio_analog_pol;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_pad_cfg_seq #(.NPADS(NPADS), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .resetb           (resetb),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .cfg_rdata        (cfg_rdata),
    .cfg_rvalid       (cfg_rvalid),
    .apply_start      (apply_start),
    .apply_busy       (apply_busy),
    .apply_done       (apply_done),
    .gpio_dm2         (gpio_dm2),
    .gpio_dm1         (gpio_dm1),
    .gpio_dm0         (gpio_dm0),
    .gpio_oeb         (gpio_oeb),
    .gpio_inp_dis     (gpio_inp_dis),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_holdover    (gpio_holdover),
    .gpio_analog_en   (gpio_analog_en),
    .gpio_analog_sel  (gpio_analog_sel),
    .gpio_analog_pol  (gpio_analog_pol)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reassembles pad k's live word from the per-field output vectors.
  function automatic logic [11:0] padWord(input int k);
    return {gpio_analog_pol[k], gpio_analog_sel[k], gpio_analog_en[k], gpio_holdover[k],
            gpio_slow_sel[k], gpio_vtrip_sel[k], gpio_ib_mode_sel[k], gpio_inp_dis[k],
            gpio_oeb[k], gpio_dm2[k], gpio_dm1[k], gpio_dm0[k]};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one request, waits (bounded) for ready, and returns the read
  // strobe/data seen on the negedge after the accepting edge plus the number
  // of cycles spent stalled.
  task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] addr, input logic [11:0] data,
                               output logic rv, output logic [11:0] rd, output int waits);
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = data;
    waits     = 0;
    while (!cfg_ready && waits < 200) begin
      nextCycle();
      waits++;
    end
    checkOutput("req_timeout", 64'(waits >= 200), 64'd0);
    nextCycle();
    rv        = cfg_rvalid;
    rd        = cfg_rdata;
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
  endtask

  // Pulses apply_start for one edge.
  task automatic startApply();
    apply_start = 1'b1;
    nextCycle();
    apply_start = 1'b0;
  endtask

  // Waits (bounded) for the sequencer to return to IDLE.
  task automatic waitIdle();
    int n = 0;
    while (apply_busy && n < 200) begin
      nextCycle();
      n++;
    end
    checkOutput("idle_timeout", 64'(n >= 200), 64'd0);
  endtask

  initial begin
    logic        rv;
    logic [11:0] rd;
    int          waits;
    int          c;
    int          busy_cnt;
    int          done_cnt;
    int          done_at;

    resetb      = 1'b0;
    cfg_valid   = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    apply_start = 1'b0;

    // Reset: three edges with resetb low.
    @(negedge clk);
    repeat (3) nextCycle();
    checkOutput("rst_dm0",   64'(gpio_dm0), 64'(ONES));
    checkOutput("rst_dm1",   64'(gpio_dm1), 64'(ZEROS));
    checkOutput("rst_dm2",   64'(gpio_dm2), 64'(ZEROS));
    checkOutput("rst_oeb",   64'(gpio_oeb), 64'(ONES));
    checkOutput("rst_inp",   64'(gpio_inp_dis | gpio_ib_mode_sel | gpio_vtrip_sel | gpio_slow_sel), 64'(ZEROS));
    checkOutput("rst_ana",   64'(gpio_holdover | gpio_analog_en | gpio_analog_sel | gpio_analog_pol), 64'(ZEROS));
    checkOutput("rst_busy",  64'(apply_busy), 64'd0);
    checkOutput("rst_done",  64'(apply_done), 64'd0);
    checkOutput("rst_ready", 64'(cfg_ready), 64'd0);
    checkOutput("rst_rdata", 64'({cfg_rvalid, cfg_rdata}), 64'd0);
    resetb = 1'b1;
    nextCycle();
    checkOutput("ready_after_rst", 64'(cfg_ready), 64'd1);

    // Shadow write then read-back; live pad untouched.
    applyStimulus(1'b1, 6'd5, 12'h0F6, rv, rd, waits);
    applyStimulus(1'b0, 6'd5, 12'h000, rv, rd, waits);
    checkOutput("rd5_rvalid", 64'(rv), 64'd1);
    checkOutput("rd5_rdata",  64'(rd), 64'h0F6);
    checkOutput("live5_def",  64'(padWord(5)), 64'(DEF));
    nextCycle();
    checkOutput("rvalid_drop", 64'({cfg_rvalid, cfg_rdata}), 64'd0);

    // Staged apply: pad k lands on the (k+1)th edge after APPLY entry.
    applyStimulus(1'b1, 6'd0,  12'h006, rv, rd, waits);
    applyStimulus(1'b1, 6'd43, 12'h206, rv, rd, waits);
    startApply();
    c        = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    checkOutput("apply_c0_pad0", 64'(padWord(0)), 64'(DEF));
    checkOutput("apply_c0_ready", 64'(cfg_ready), 64'd0);
    while (apply_busy && c < 100) begin
      busy_cnt++;
      if (apply_done) begin
        done_cnt++;
        done_at = c;
      end
      nextCycle();
      c++;
      if (c == 1)  checkOutput("apply_c1_pad0",   64'(padWord(0)),  64'h006);
      if (c == 5)  checkOutput("apply_c5_pad5",   64'(padWord(5)),  64'(DEF));
      if (c == 6)  checkOutput("apply_c6_pad5",   64'(padWord(5)),  64'h0F6);
      if (c == 43) checkOutput("apply_c43_pad43", 64'(padWord(43)), 64'(DEF));
      if (c == 44) checkOutput("apply_c44_pad43", 64'(padWord(43)), 64'h206);
    end
    checkOutput("apply_busy_cycles", 64'(busy_cnt), 64'd45);
    checkOutput("apply_done_count",  64'(done_cnt), 64'd1);
    checkOutput("apply_done_at",     64'(done_at),  64'd44);

    // Request issued during apply stalls until IDLE; the shadow stays frozen,
    // so pad 7 is copied as DEF.
    startApply();
    applyStimulus(1'b1, 6'd7, 12'h0AA, rv, rd, waits);
    checkOutput("stall_waits", 64'(waits), 64'd45);
    checkOutput("stall_live7", 64'(padWord(7)), 64'(DEF));
    applyStimulus(1'b0, 6'd7, 12'h000, rv, rd, waits);
    checkOutput("stall_rd7", 64'(rd), 64'h0AA);

    // Out-of-range address: write dropped, read returns zero with strobe.
    applyStimulus(1'b1, 6'd50, 12'hFFF, rv, rd, waits);
    applyStimulus(1'b0, 6'd50, 12'h000, rv, rd, waits);
    checkOutput("oor_rvalid", 64'(rv), 64'd1);
    checkOutput("oor_rdata",  64'(rd), 64'h000);
    applyStimulus(1'b0, 6'd5, 12'h000, rv, rd, waits);
    checkOutput("oor_rd5", 64'(rd), 64'h0F6);

    // apply_start while in DONE must be dropped.
    startApply();
    c = 0;
    while (!apply_done && c < 100) begin
      nextCycle();
      c++;
    end
    checkOutput("done_seen", 64'(apply_done), 64'd1);
    apply_start = 1'b1;
    nextCycle();
    apply_start = 1'b0;
    checkOutput("done_start_busy0", 64'(apply_busy), 64'd0);
    nextCycle();
    checkOutput("done_start_busy1", 64'(apply_busy), 64'd0);

    // Reset in the middle of an apply restores every live pad.
    applyStimulus(1'b1, 6'd3, 12'h1C9, rv, rd, waits);
    startApply();
    repeat (20) nextCycle();
    checkOutput("mid_live3", 64'(padWord(3)), 64'h1C9);
    resetb = 1'b0;
    nextCycle();
    checkOutput("abort_pad0",  64'(padWord(0)), 64'(DEF));
    checkOutput("abort_pad3",  64'(padWord(3)), 64'(DEF));
    checkOutput("abort_pad5",  64'(padWord(5)), 64'(DEF));
    checkOutput("abort_busy",  64'(apply_busy), 64'd0);
    checkOutput("abort_ready", 64'(cfg_ready), 64'd0);
    resetb = 1'b1;
    nextCycle();

    // Write and apply_start on the same edge: the write is included.
    cfg_valid   = 1'b1;
    cfg_we      = 1'b1;
    cfg_addr    = 6'd10;
    cfg_wdata   = 12'h155;
    apply_start = 1'b1;
    nextCycle();
    cfg_valid   = 1'b0;
    cfg_we      = 1'b0;
    apply_start = 1'b0;
    checkOutput("same_busy", 64'(apply_busy), 64'd1);
    waitIdle();
    checkOutput("same_pad10", 64'(padWord(10)), 64'h155);
    checkOutput("same_pad0",  64'(padWord(0)),  64'(DEF));
    checkOutput("same_pad43", 64'(padWord(43)), 64'(DEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
